// File: rtl/gpio_pad_arbiter_if.sv
// Requester-side bundle of the GPIO pad arbiter: level requests, one-hot grants
// and the per-requester pad slices, packed as slice r = [r*N_PADS +: N_PADS].
`timescale 1ns/1ps
interface gpio_pad_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int N_PADS = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ*N_PADS-1:0] req_out;
    logic [N_REQ*N_PADS-1:0] req_oe;
    logic [N_REQ*N_PADS-1:0] req_in;

    modport master (
        output req,
        output req_out,
        output req_oe,
        input  gnt,
        input  req_in
    );

    modport slave (
        input  req,
        input  req_out,
        input  req_oe,
        output gnt,
        output req_in
    );
endinterface

// File: rtl/gpio_pad_arbiter.sv
// Round-robin owner of a shared GPIO pad bank: exclusive grants separated by an
// all-tristate turnaround, with an optional hold timeout that revokes long grants.
`timescale 1ns/1ps
module gpio_pad_arbiter #(
    parameter int N_REQ      = 4,
    parameter int N_PADS     = 8,
    parameter int TURNAROUND = 2,
    parameter int W_TIMEOUT  = 8,
    localparam int W_IDX     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_pad_arbiter_if.slave    bus,
    output logic [N_PADS-1:0]    pad_out_o,
    output logic [N_PADS-1:0]    pad_oe_o,
    input  logic [N_PADS-1:0]    pad_in_i,
    input  logic [W_TIMEOUT-1:0] timeout_cycles_i,
    output logic [W_IDX-1:0]     owner_o,
    output logic                 busy_o,
    output logic                 revoke_o
);

    localparam int W_TURN = (TURNAROUND < 2) ? 1 : $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [W_IDX-1:0]     owner_q, owner_d;
    logic [W_IDX-1:0]     ptr_q, ptr_d;
    logic [W_TURN-1:0]    turn_q, turn_d;
    logic [W_TIMEOUT-1:0] hold_q, hold_d;
    logic                 revoke_q, revoke_d;

    logic [W_IDX-1:0]     winner_s;
    logic [W_IDX-1:0]     next_ptr_s;
    logic                 others_wait_s;
    logic                 timeout_hit_s;
    logic [N_PADS-1:0]    pad_out_s;
    logic [N_PADS-1:0]    pad_oe_s;

    // First set request bit scanning upward from p, wrapping modulo N_REQ.
    function automatic logic [W_IDX-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [W_IDX-1:0] p);
        logic [W_IDX-1:0] w;
        logic             found;
        int               sum;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(p) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end else begin
                sum = sum;
            end
            if (!found && r[W_IDX'(sum)]) begin
                w     = W_IDX'(sum);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [W_IDX-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign winner_s      = rr_pick(bus.req, ptr_q);
    assign next_ptr_s    = (owner_q == W_IDX'(N_REQ - 1)) ? '0 : owner_q + W_IDX'(1);
    assign others_wait_s = |(bus.req & ~onehot(owner_q));
    // timeout_cycles is non-zero here, so the minus one cannot wrap.
    assign timeout_hit_s = (timeout_cycles_i != '0) &&
                           (hold_q >= (timeout_cycles_i - W_TIMEOUT'(1))) &&
                           others_wait_s;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            turn_q   <= '0;
            hold_q   <= '0;
            revoke_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            turn_q   <= turn_d;
            hold_q   <= hold_d;
            revoke_q <= revoke_d;
        end
    end

    // Next-state logic; release takes priority over timeout so a voluntary exit never pulses revoke.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        turn_d   = turn_q;
        hold_d   = hold_q;
        revoke_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (|bus.req) begin
                    owner_d = winner_s;
                    turn_d  = W_TURN'(TURNAROUND);
                    state_d = ST_TURN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (!bus.req[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr_s;
                end else if (turn_q <= W_TURN'(1)) begin
                    state_d = ST_OWN;
                    gnt_d   = onehot(owner_q);
                    hold_d  = '0;
                    ptr_d   = next_ptr_s;
                end else begin
                    turn_d  = turn_q - W_TURN'(1);
                end
            end
            ST_OWN: begin
                if (!bus.req[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr_s;
                end else if (timeout_hit_s) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    ptr_d    = next_ptr_s;
                    revoke_d = 1'b1;
                end else if (hold_q == '1) begin
                    hold_d = hold_q;
                end else begin
                    hold_d = hold_q + W_TIMEOUT'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Pad mux: gnt is one-hot, so OR-ing every gated slice selects the owner.
    always_comb begin
        pad_out_s = '0;
        pad_oe_s  = '0;
        for (int r = 0; r < N_REQ; r++) begin
            pad_out_s = pad_out_s | (bus.req_out[r*N_PADS +: N_PADS] & {N_PADS{gnt_q[r]}});
            pad_oe_s  = pad_oe_s  | (bus.req_oe[r*N_PADS +: N_PADS]  & {N_PADS{gnt_q[r]}});
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_req_in
        assign bus.req_in[g*N_PADS +: N_PADS] = pad_in_i & {N_PADS{gnt_q[g]}};
    end

    assign bus.gnt   = gnt_q;
    assign pad_out_o = pad_out_s;
    assign pad_oe_o  = pad_oe_s;
    assign owner_o   = owner_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign revoke_o  = revoke_q;

endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// Vector-table bench for gpio_pad_arbiter: each record is driven after a rising
// edge, queued as the expected outcome, then popped and compared on the falling edge.
`timescale 1ns/1ps
module tb_gpio_pad_arbiter;

    localparam int N_REQ  = 4;
    localparam int N_PADS = 8;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] tmo;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       revoke;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  tmo;
    logic [7:0]  pad_in;
    logic [7:0]  pad_out;
    logic [7:0]  pad_oe;
    logic [1:0]  owner;
    logic        busy;
    logic        revoke;

    int n_pass  = 0;
    int n_total = 0;

    vec_t tbl[$];
    vec_t sb[$];

    gpio_pad_arbiter_if #(.N_REQ(N_REQ), .N_PADS(N_PADS)) bus ();

    gpio_pad_arbiter #(
        .N_REQ(N_REQ), .N_PADS(N_PADS), .TURNAROUND(2), .W_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .pad_out_o(pad_out),
        .pad_oe_o(pad_oe),
        .pad_in_i(pad_in),
        .timeout_cycles_i(tmo),
        .owner_o(owner),
        .busy_o(busy),
        .revoke_o(revoke)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [7:0] t,
                                input logic [3:0] g, input logic [1:0] o,
                                input logic b, input logic v);
        vec_t x;
        x.rst = r; x.req = q; x.tmo = t; x.gnt = g; x.owner = o; x.busy = b; x.revoke = v;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Compare every observable output against the record, pads modelled from the driven slices.
    task automatic compare(input vec_t e, input string tag);
        logic [7:0]  x_oe;
        logic [7:0]  x_out;
        logic [31:0] x_in;
        x_oe = 8'h00; x_out = 8'h00; x_in = 32'h0;
        for (int r = 0; r < N_REQ; r++) begin
            if (e.gnt[r]) begin
                x_oe  = bus.req_oe[r*N_PADS +: N_PADS];
                x_out = bus.req_out[r*N_PADS +: N_PADS];
                x_in[r*N_PADS +: N_PADS] = pad_in;
            end
        end
        check({tag, " gnt"},     64'(bus.gnt),    64'(e.gnt));
        check({tag, " owner"},   64'(owner),      64'(e.owner));
        check({tag, " busy"},    64'(busy),       64'(e.busy));
        check({tag, " revoke"},  64'(revoke),     64'(e.revoke));
        check({tag, " pad_oe"},  64'(pad_oe),     64'(x_oe));
        check({tag, " pad_out"}, 64'(pad_out),    64'(x_out));
        check({tag, " req_in"},  64'(bus.req_in), 64'(x_in));
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(posedge clk);
        #1;
        rst     = v.rst;
        bus.req = v.req;
        tmo     = v.tmo;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        compare(e, tag);
    endtask

    initial begin
        rst         = 1'b1;
        tmo         = 8'd0;
        pad_in      = 8'h5A;
        bus.req     = 4'b0000;
        for (int r = 0; r < N_REQ; r++) begin
            bus.req_oe[r*N_PADS +: N_PADS]  = 8'(8'h11 * (r + 1));
            bus.req_out[r*N_PADS +: N_PADS] = 8'(8'hA0 + r);
        end

        //            rst   req     tmo    gnt      own   busy  rev
        tbl.push_back(mk(1'b1, 4'b0000, 8'd0, 4'b0000, 2'd0, 1'b0, 1'b0)); // reset state
        // single request: gnt three cycles after the request
        tbl.push_back(mk(1'b0, 4'b0010, 8'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 8'd0, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 8'd0, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 8'd0, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 8'd0, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 8'd0, 4'b0000, 2'd1, 1'b0, 1'b0));
        // two requesters from reset, handover gap of IDLE + TURNAROUND
        tbl.push_back(mk(1'b1, 4'b0101, 8'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0101, 8'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0101, 8'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0101, 8'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0101, 8'd0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 8'd0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 8'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 8'd0, 4'b0000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 8'd0, 4'b0000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 8'd0, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 8'd0, 4'b0100, 2'd2, 1'b1, 1'b0));
        // ptr is 3 after requester 2 releases: all-request picks 3
        tbl.push_back(mk(1'b0, 4'b1111, 8'd0, 4'b0000, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 8'd0, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 8'd0, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, 8'd0, 4'b1000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 8'd0, 4'b1000, 2'd3, 1'b1, 1'b0));
        // request abandoned during TURN, then the other requester is served
        tbl.push_back(mk(1'b0, 4'b0100, 8'd0, 4'b0000, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 8'd0, 4'b0000, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 8'd0, 4'b0000, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 8'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 8'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 8'd0, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 8'd0, 4'b0001, 2'd0, 1'b1, 1'b0));
        // timeout of 4 with a waiting requester: revoke pulse, then handover
        tbl.push_back(mk(1'b0, 4'b0010, 8'd4, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0000, 2'd1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 8'd4, 4'b1000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 8'd4, 4'b0000, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0000, 2'd1, 1'b1, 1'b0));
        // release coinciding with timeout: no revoke pulse
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1010, 8'd4, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, 8'd4, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 8'd0, 4'b0000, 2'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 8'd0, 4'b0000, 2'd1, 1'b0, 1'b0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // timeout disabled, all requesting: ptr is 2, grant never leaves requester 2
        for (int i = 0; i < 1003; i++) begin
            step(mk(1'b0, 4'b1111, 8'd0, (i >= 3) ? 4'b0100 : 4'b0000,
                    (i == 0) ? 2'd1 : 2'd2, (i > 0) ? 1'b1 : 1'b0, 1'b0),
                 $sformatf("hold%0d", i));
        end

        // async reset mid-OWN with every pad driven
        for (int r = 0; r < N_REQ; r++) begin
            bus.req_oe[r*N_PADS +: N_PADS] = 8'hFF;
        end
        step(mk(1'b0, 4'b1111, 8'd0, 4'b0100, 2'd2, 1'b1, 1'b0), "pre_rst");
        check("pre_rst pad_oe_ff", 64'(pad_oe), 64'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst gnt",    64'(bus.gnt), 64'h0);
        check("async_rst pad_oe", 64'(pad_oe),  64'h0);
        check("async_rst busy",   64'(busy),    64'h0);
        check("async_rst revoke", 64'(revoke),  64'h0);
        check("async_rst owner",  64'(owner),   64'h0);
        // ptr back at 0: requesters 1 and 3 waiting picks 1
        step(mk(1'b1, 4'b1010, 8'd0, 4'b0000, 2'd0, 1'b0, 1'b0), "rst_hold");
        step(mk(1'b0, 4'b1010, 8'd0, 4'b0000, 2'd0, 1'b0, 1'b0), "rst_rel");
        step(mk(1'b0, 4'b1010, 8'd0, 4'b0000, 2'd1, 1'b1, 1'b0), "rst_turn1");
        step(mk(1'b0, 4'b1010, 8'd0, 4'b0000, 2'd1, 1'b1, 1'b0), "rst_turn2");
        step(mk(1'b0, 4'b1010, 8'd0, 4'b0010, 2'd1, 1'b1, 1'b0), "rst_own");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
